dendrite_arbiter: RTL



---
 rtl/dendrite_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/dendrite_arbiter.sv
// Merges NUM_SYN synapse fire streams and one priority incoming stream into a
// single registered fire stream for the dendrite unit.
//
// Handshake: a port transfers on a cycle where its vld and rdy are both high.
// vld must not depend on rdy. dend_vld/dend_addr/dend_charge hold steady while
// dend_vld=1 and dend_rdy=0.
module dendrite_arbiter #(
  parameter int NUM_SYN = 4,
  parameter int ADDR_W  = 8,
  parameter int CHG_W   = 8,
  parameter int RR_EN   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [NUM_SYN*ADDR_W-1:0] syn_addr,
  input  logic [NUM_SYN*CHG_W-1:0]  syn_charge,
  input  logic [NUM_SYN-1:0]        syn_vld,
  output logic [NUM_SYN-1:0]        syn_rdy,
  input  logic [ADDR_W-1:0]         incoming_addr,
  input  logic [CHG_W-1:0]          incoming_charge,
  input  logic                      incoming_vld,
  output logic                      incoming_rdy,
  output logic [ADDR_W-1:0]         dend_addr,
  output logic [CHG_W:0]            dend_charge,
  output logic                      dend_vld,
  input  logic                      dend_rdy,
  output logic                      busy
);

  localparam int PTR_W = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1;
  localparam logic [PTR_W:0] NUM_SYN_P = (PTR_W+1)'(NUM_SYN);

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  ptr_next;
  logic [PTR_W:0]    cand;
  logic [PTR_W:0]    ptr_inc;
  logic              load_ok;
  logic              inc_gnt;
  logic              syn_found;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [CHG_W-1:0]  syn_chg_sel;
  logic [CHG_W:0]    sel_charge;

  // Grant search starts at rr_ptr (round-robin) or at port 0 (fixed priority).
  always_comb begin
    load_ok   = enable & ~reset & (~dend_vld | dend_rdy);
    inc_gnt   = 1'b0;
    syn_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (load_ok && incoming_vld) begin
      inc_gnt = 1'b1;
    end else if (load_ok) begin
      for (int k = 0; k < NUM_SYN; k++) begin
        if (RR_EN != 0) begin
          cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
          if (cand >= NUM_SYN_P) cand = cand - NUM_SYN_P;
        end else begin
          cand = (PTR_W+1)'(k);
        end
        if (!syn_found && syn_vld[cand[PTR_W-1:0]]) begin
          syn_found = 1'b1;
          gnt_idx   = cand[PTR_W-1:0];
        end
      end
    end
  end

  assign syn_rdy      = syn_found ? (NUM_SYN'(1) << gnt_idx) : '0;
  assign incoming_rdy = inc_gnt;
  assign xfer         = inc_gnt | syn_found;
  assign busy         = dend_vld | incoming_vld | (|syn_vld);

  // Synapse charges are signed; the incoming charge is unsigned.
  assign syn_chg_sel = syn_charge[gnt_idx*CHG_W +: CHG_W];
  assign sel_addr    = inc_gnt ? incoming_addr : syn_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign sel_charge  = inc_gnt ? {1'b0, incoming_charge}
                               : {syn_chg_sel[CHG_W-1], syn_chg_sel};

  assign ptr_inc  = {1'b0, gnt_idx} + (PTR_W+1)'(1);
  assign ptr_next = (ptr_inc == NUM_SYN_P) ? '0 : ptr_inc[PTR_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dend_vld    <= 1'b0;
      dend_addr   <= '0;
      dend_charge <= '0;
      rr_ptr      <= '0;
    end else begin
      if (xfer) begin
        dend_vld    <= 1'b1;
        dend_addr   <= sel_addr;
        dend_charge <= sel_charge;
        if (syn_found && (RR_EN != 0)) rr_ptr <= ptr_next;
      end else if (dend_vld && dend_rdy) begin
        dend_vld <= 1'b0;
      end
    end
  end

endmodule
